// File: rtl/maxpool_pkg.sv
// -----------------------------------------------------------------------------
// maxpool_pkg
// Shared definitions for the streaming max-pool reducer.
//   - count_width / lane_width / idx_width : sizing helpers for counters and
//     index fields, never narrower than one bit.
//   - state_t : output FSM states.
//   - gt      : strict greater-than used everywhere a word is compared, so the
//               tree and the accumulator always agree on ordering.
// No ports (package).
// -----------------------------------------------------------------------------
package maxpool_pkg;

    // Width of a counter able to hold the value max_beats
    function automatic int count_width(input int max_beats);
        return (max_beats > 0) ? $clog2(max_beats + 1) : 1;
    endfunction

    // Width of a lane number within one beat
    function automatic int lane_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Width of a flat element index beat*lanes + lane over a full window
    function automatic int idx_width(input int lanes, input int max_beats);
        return (lanes * max_beats > 1) ? $clog2(lanes * max_beats) : 1;
    endfunction

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    // Operands arrive zero-extended to 64 bits (word widths up to 64 are
    // supported). Flipping the sign bit of a two's-complement word maps the
    // signed ordering onto the unsigned one, so a single unsigned compare
    // serves both modes.
    function automatic logic gt(input logic [63:0] a,
                                input logic [63:0] b,
                                input logic        signed_mode,
                                input int          width);
        logic [63:0] flip;
        flip = signed_mode ? (64'd1 << (width - 1)) : 64'd0;
        return (a ^ flip) > (b ^ flip);
    endfunction

endpackage

// File: rtl/maxpool_tree.sv
// -----------------------------------------------------------------------------
// maxpool_tree
// Purely combinational reduction of one beat of LANES words to its maximum,
// built as log2(LANES) levels of pairwise compare/mux. On equal values the
// lower lane wins, so the reported lane is the earliest occurrence of the max.
// With LANES=1 lane 0 is passed straight through.
// Ports:
//   in_data  [LANES*W-1:0]  lane k at bits [k*W +: W]
//   max_val  [W-1:0]        largest word of the beat
//   max_lane [LW-1:0]       lane holding max_val
// -----------------------------------------------------------------------------
module maxpool_tree
    import maxpool_pkg::*;
#(
    parameter int W      = 16,
    parameter int LANES  = 16,
    parameter int SIGNED = 0
) (
    input  logic [LANES*W-1:0]            in_data,
    output logic [W-1:0]                  max_val,
    output logic [lane_width(LANES)-1:0]  max_lane
);

    localparam int LW     = lane_width(LANES);
    localparam int LEVELS = (LANES > 1) ? $clog2(LANES) : 0;

    logic [W-1:0]  node_val  [LANES];
    logic [LW-1:0] node_lane [LANES];

    // Reduce in place: at each level node n takes the winner of nodes 2n and
    // 2n+1 from the previous level. Node n is written only after both of its
    // sources have been read, so a single array is enough. The right (higher
    // lane) input must be strictly greater to win, which keeps ties on the
    // lower lane.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            node_val[k]  = in_data[k*W +: W];
            node_lane[k] = LW'(k);
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int n = 0; n < (LANES >> (l + 1)); n++) begin
                if (gt(64'(node_val[2*n+1]), 64'(node_val[2*n]), SIGNED != 0, W)) begin
                    node_val[n]  = node_val[2*n+1];
                    node_lane[n] = node_lane[2*n+1];
                end else begin
                    node_val[n]  = node_val[2*n];
                    node_lane[n] = node_lane[2*n];
                end
            end
        end
        max_val  = node_val[0];
        max_lane = node_lane[0];
    end

endmodule

// File: rtl/maxpool_stream.sv
// -----------------------------------------------------------------------------
// maxpool_stream
// Streaming max-pool reducer. Each accepted beat of LANES words is reduced by
// maxpool_tree; the beat maxima are folded across a window of cfg_beats beats
// and the window maximum is offered on a valid/ready output one clock after
// the last input handshake. A new window's first beat may be accepted in the
// same cycle the previous result is consumed, so back-to-back windows run with
// no bubble.
// Optional feature macro: MAXPOOL_ARGMAX_EN adds the out_idx port carrying the
// flat index beat*LANES + lane of the (earliest) maximum.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   cfg_beats  window length in beats (0 -> 1, >MAX_BEATS -> MAX_BEATS),
//              sampled on the first beat of each window
//   in_valid / in_ready / in_data   input beat handshake and payload
//   out_valid / out_ready           result handshake
//   out_max    window maximum
//   out_idx    argmax index (only with MAXPOOL_ARGMAX_EN)
// -----------------------------------------------------------------------------
module maxpool_stream
    import maxpool_pkg::*;
#(
    parameter int W         = 16,
    parameter int LANES     = 16,
    parameter int MAX_BEATS = 16,
    parameter int SIGNED    = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [count_width(MAX_BEATS)-1:0]  cfg_beats,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [LANES*W-1:0]                 in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [W-1:0]                       out_max
`ifdef MAXPOOL_ARGMAX_EN
    ,
    output logic [idx_width(LANES, MAX_BEATS)-1:0] out_idx
`endif
);

    localparam int CW = count_width(MAX_BEATS);
    localparam int LW = lane_width(LANES);
    localparam int IW = idx_width(LANES, MAX_BEATS);

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  beat_cnt_q;
    logic [CW-1:0]  len_q;
    logic [W-1:0]   acc_max_q;

    logic [W-1:0]   tree_max;
    logic [LW-1:0]  tree_lane;
    logic [CW-1:0]  cfg_len;
    logic [CW-1:0]  eff_len;
    logic           in_fire;
    logic           first_beat;
    logic           last_beat;
    logic           take_tree;

    maxpool_tree #(
        .W      (W),
        .LANES  (LANES),
        .SIGNED (SIGNED)
    ) u_tree (
        .in_data  (in_data),
        .max_val  (tree_max),
        .max_lane (tree_lane)
    );

    // Window length as it would be latched right now: zero means a single
    // beat and anything beyond MAX_BEATS is clamped.
    always_comb begin
        if (cfg_beats == '0) begin
            cfg_len = CW'(1);
        end else if (cfg_beats > CW'(MAX_BEATS)) begin
            cfg_len = CW'(MAX_BEATS);
        end else begin
            cfg_len = cfg_beats;
        end
    end

    // The first beat of a window uses the fresh cfg length (it is also the
    // beat that latches it); later beats use the latched copy so mid-window
    // cfg changes are ignored. The first beat always loads the accumulator,
    // later beats only on a strictly greater value so ties keep the earlier
    // element.
    always_comb begin
        in_fire    = in_valid && in_ready;
        first_beat = (beat_cnt_q == '0);
        eff_len    = first_beat ? cfg_len : len_q;
        last_beat  = in_fire && (beat_cnt_q == eff_len - CW'(1));
        take_tree  = first_beat || gt(64'(tree_max), 64'(acc_max_q), SIGNED != 0, W);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs. In OUT the input is only accepted
    // together with consumption of the result; if that beat completes a
    // one-beat window we stay in OUT with the new result.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                if (last_beat) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = last_beat ? OUT : ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Beat counter, latched window length and running maximum. The running
    // maximum doubles as the output register: it only moves on an accepted
    // beat, which in OUT cannot happen before the result is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            len_q      <= '0;
            acc_max_q  <= '0;
        end else if (in_fire) begin
            beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CW'(1);
            if (first_beat) begin
                len_q <= cfg_len;
            end
            if (take_tree) begin
                acc_max_q <= tree_max;
            end
        end
    end

    assign out_max = acc_max_q;

`ifdef MAXPOOL_ARGMAX_EN
    logic [IW-1:0] cand_idx;
    logic [IW-1:0] acc_idx_q;

    // Flat index of the tree winner within the window
    always_comb begin
        cand_idx = IW'(32'(beat_cnt_q) * LANES + 32'(tree_lane));
    end

    // Argmax follows the same load/replace decision as the running maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_idx_q <= '0;
        end else if (in_fire && take_tree) begin
            acc_idx_q <= cand_idx;
        end
    end

    assign out_idx = acc_idx_q;
`else
    logic unused_tree_lane;
    assign unused_tree_lane = ^tree_lane;
`endif

endmodule

// File: tb/tb_maxpool_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool_stream
// Drives an unsigned and a signed maxpool_stream with identical stimulus and
// compares both against a window-level reference: accepted beats are collected
// per window and the result is the first occurrence of the largest word when
// the window is complete. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_maxpool_stream;
    import maxpool_pkg::*;

    localparam int W         = 16;
    localparam int LANES     = 16;
    localparam int MAX_BEATS = 16;
    localparam int CW        = count_width(MAX_BEATS);
    localparam int IW        = idx_width(LANES, MAX_BEATS);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [CW-1:0]       cfg_beats = '0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic [LANES*W-1:0]  in_data = '0;
    logic                in_ready_u, in_ready_s;
    logic                out_valid_u, out_valid_s;
    logic [W-1:0]        out_max_u, out_max_s;
`ifdef MAXPOOL_ARGMAX_EN
    logic [IW-1:0]       out_idx_u, out_idx_s;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [LANES*W-1:0]  win_q[$];
    int                  win_len;
    bit                  exp_valid;
    logic [W-1:0]        exp_max_u, exp_max_s;
    int                  exp_idx_u, exp_idx_s;

    always #5 clk = ~clk;

    maxpool_stream #(.W(W), .LANES(LANES), .MAX_BEATS(MAX_BEATS), .SIGNED(0)) dut_u (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_beats (cfg_beats),
        .in_valid  (in_valid),
        .in_ready  (in_ready_u),
        .in_data   (in_data),
        .out_valid (out_valid_u),
        .out_ready (out_ready),
        .out_max   (out_max_u)
`ifdef MAXPOOL_ARGMAX_EN
        ,
        .out_idx   (out_idx_u)
`endif
    );

    maxpool_stream #(.W(W), .LANES(LANES), .MAX_BEATS(MAX_BEATS), .SIGNED(1)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_beats (cfg_beats),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_data),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_max   (out_max_s)
`ifdef MAXPOOL_ARGMAX_EN
        ,
        .out_idx   (out_idx_s)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LANES*W-1:0] fill(input logic [W-1:0] v);
        logic [LANES*W-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*W +: W] = v;
        return r;
    endfunction

    function automatic logic [LANES*W-1:0] rand_beat();
        logic [LANES*W-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            if ($urandom_range(0, 3) == 0) r[k*W +: W] = W'($urandom);
            else                           r[k*W +: W] = W'($urandom_range(0, 15));
        end
        return r;
    endfunction

    function automatic int clamp_len(input int cfg);
        if (cfg == 0) return 1;
        if (cfg > MAX_BEATS) return MAX_BEATS;
        return cfg;
    endfunction

    // Scan the window in arrival order; only a strictly larger word displaces
    // the current best, so the earliest maximum wins.
    task automatic window_result(input bit signed_mode, output logic [W-1:0] best, output int best_idx);
        logic [LANES*W-1:0] beat;
        logic [W-1:0]       val;
        bit                 better;
        best     = '0;
        best_idx = -1;
        for (int b = 0; b < win_q.size(); b++) begin
            beat = win_q[b];
            for (int k = 0; k < LANES; k++) begin
                val = beat[k*W +: W];
                if (best_idx < 0)     better = 1'b1;
                else if (signed_mode) better = $signed(val) > $signed(best);
                else                  better = val > best;
                if (better) begin
                    best     = val;
                    best_idx = b * LANES + k;
                end
            end
        end
    endtask

    task automatic checkResults(input string tag);
        checkOutput({tag, ".out_valid_u"}, 32'(out_valid_u), 32'(exp_valid));
        checkOutput({tag, ".out_valid_s"}, 32'(out_valid_s), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput({tag, ".out_max_u"}, 32'(out_max_u), 32'(exp_max_u));
            checkOutput({tag, ".out_max_s"}, 32'(out_max_s), 32'(exp_max_s));
`ifdef MAXPOOL_ARGMAX_EN
            checkOutput({tag, ".out_idx_u"}, 32'(out_idx_u), 32'(exp_idx_u));
            checkOutput({tag, ".out_idx_s"}, 32'(out_idx_s), 32'(exp_idx_s));
`endif
        end
    endtask

    // One clock of stimulus, entered and left on a falling edge
    task automatic applyStimulus(input string tag, input bit vld, input bit rdy,
                                 input logic [LANES*W-1:0] data, input int cfg);
        bit fire;
        in_valid  = vld;
        out_ready = rdy;
        in_data   = data;
        cfg_beats = CW'(cfg);
        #1;
        checkOutput({tag, ".in_ready_u"}, 32'(in_ready_u), 32'(!exp_valid || rdy));
        checkOutput({tag, ".in_ready_s"}, 32'(in_ready_s), 32'(!exp_valid || rdy));
        fire = vld && (!exp_valid || rdy);
        @(posedge clk);
        if (exp_valid && rdy) exp_valid = 1'b0;
        if (fire) begin
            if (win_q.size() == 0) win_len = clamp_len(cfg);
            win_q.push_back(data);
            if (win_q.size() == win_len) begin
                window_result(1'b0, exp_max_u, exp_idx_u);
                window_result(1'b1, exp_max_s, exp_idx_s);
                exp_valid = 1'b1;
                win_q.delete();
            end
        end
        @(negedge clk);
        checkResults(tag);
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        win_q.delete();
        exp_valid = 1'b0;
        #1;
        checkOutput({tag, ".rst_out_valid"}, 32'(out_valid_u | out_valid_s), 32'd0);
        checkOutput({tag, ".rst_out_max_u"}, 32'(out_max_u), 32'd0);
        checkOutput({tag, ".rst_out_max_s"}, 32'(out_max_s), 32'd0);
        checkOutput({tag, ".rst_in_ready"}, 32'(in_ready_u & in_ready_s), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [LANES*W-1:0] d;

        doReset("reset");

        // Single-beat window, 9 first appears at lane 1
        d = fill(16'd9);
        d[0 +: W] = 16'd3;
        applyStimulus("t1", 1'b1, 1'b1, d, 1);
        checkOutput("t1.max_const", 32'(out_max_u), 32'd9);
`ifdef MAXPOOL_ARGMAX_EN
        checkOutput("t1.idx_const", 32'(out_idx_u), 32'd1);
`endif
        applyStimulus("t1.drain", 1'b0, 1'b1, '0, 1);

        // Three-beat window with a repeated maximum in a later beat
        d = fill(16'd100);
        applyStimulus("t2.b0", 1'b1, 1'b1, d, 3);
        d = fill(16'd5);
        d[7*W +: W] = 16'd250;
        applyStimulus("t2.b1", 1'b1, 1'b1, d, 9);
        d = fill(16'd7);
        d[4*W +: W] = 16'd250;
        applyStimulus("t2.b2", 1'b1, 1'b1, d, 9);
        checkOutput("t2.max_const", 32'(out_max_u), 32'd250);
`ifdef MAXPOOL_ARGMAX_EN
        checkOutput("t2.idx_const", 32'(out_idx_u), 32'd23);
`endif

        // Signed vs unsigned ordering; the result then sits under back-pressure
        d = fill(16'h8000);
        d[3*W +: W]  = 16'hFFFF;
        d[10*W +: W] = 16'h0002;
        applyStimulus("t3", 1'b1, 1'b1, d, 1);
        checkOutput("t3.max_u_const", 32'(out_max_u), 32'hFFFF);
        checkOutput("t3.max_s_const", 32'(out_max_s), 32'h0002);
        for (int i = 0; i < 5; i++) applyStimulus("t4.stall", 1'b1, 1'b0, rand_beat(), 1);
        checkOutput("t4.held_u", 32'(out_max_u), 32'hFFFF);
        applyStimulus("t4.release", 1'b1, 1'b1, rand_beat(), 1);
        applyStimulus("t4.drain", 1'b0, 1'b1, '0, 1);

        // cfg_beats=0 behaves as one-beat windows at full throughput
        for (int i = 0; i < 6; i++) applyStimulus("t5.b2b", 1'b1, 1'b1, rand_beat(), 0);
        applyStimulus("t5.drain", 1'b0, 1'b1, '0, 0);

        // Reset in the middle of a four-beat window
        applyStimulus("t6.pre0", 1'b1, 1'b1, fill(16'hF000), 4);
        applyStimulus("t6.pre1", 1'b1, 1'b1, fill(16'hF001), 4);
        doReset("t6");
        for (int i = 0; i < 4; i++) applyStimulus("t6.post", 1'b1, 1'b1, rand_beat(), 4);
        applyStimulus("t6.drain", 1'b0, 1'b1, '0, 4);

        // Random traffic: sporadic valid/ready and cfg changing every cycle,
        // including out-of-range lengths that must clamp
        for (int i = 0; i < 600; i++) begin
            applyStimulus("rand",
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0,
                          rand_beat(),
                          int'($urandom_range(0, 20)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
- Streaming, parametrised max-pooling reducer for the secure-inference / auction datapath.
- Each accepted beat carries LANES words of W bits. A combinational lane tree reduces a beat to one maximum. A sequential accumulator folds that maximum across a runtime-configured number of beats (the window).
- After the last beat of a window it presents the window maximum, and optionally its argmax index, on a valid/ready output.
- Successor to the fixed 16x16 combinational max tree: generic width/lanes, signed mode, back-pressure, multi-beat windows.

Parameters:
- W, 16, word width in bits (>=2).
- LANES, 16, words per input beat; power of 2, >=1.
- MAX_BEATS, 16, largest window in beats (>=1).
- SIGNED, 0, 1 = two's-complement compare; 0 = unsigned.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_beats  in  $clog2(MAX_BEATS+1)  window length in beats; sampled on the first beat of each window.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*W  lane k at bits [k*W +: W].
- out_valid  out  1  window result valid.
- out_ready  in  1  consumer accepts the result.
- out_max  out  W  window maximum.
- out_idx  out  $clog2(LANES*MAX_BEATS)  argmax index; present only with MAXPOOL_ARGMAX_EN.

Behaviour:
- One clock, asynchronous active-low reset; all flops clear on rst_n low.
- Reset values: state=ACCUM, beat counter=0, accumulator=0, out_valid=0, out_max=0, out_idx=0.
- FSM states:
  - ACCUM: in_ready=1, out_valid=0.
  - OUT: out_valid=1; in_ready=out_ready.
- First beat of a window (counter==0):
  - Latch the effective length L = cfg_beats, with 0 treated as 1 and values >MAX_BEATS clamped to MAX_BEATS.
  - Load the accumulator directly with the tree result; do not compare against the old value.
- Later beats: replace the accumulator only if the tree max is strictly greater than it. Ties keep the earlier (lower-index) element. In the tree, ties likewise keep the lower lane.
- Compare is unsigned when SIGNED=0 and signed when SIGNED=1. No width growth; out_max is an exact copy of an input word.
- Counter increments per accepted beat. When the beat with counter==L-1 is accepted:
  - Go to OUT.
  - Reset the counter to 0.
  - out_max/out_idx show the final value in the next cycle.
  - Latency: one clock from the last input handshake to out_valid.
- OUT holds out_max/out_idx stable until out_ready.
- In OUT with out_ready=1, the result is consumed:
  - in_valid=0: return to ACCUM.
  - in_valid=1: the beat is the first beat of the next window. Load the accumulator and stay in OUT only if L==1; otherwise go to ACCUM. This gives full throughput with no bubble.
- in_data is ignored when no handshake occurs.
- cfg_beats changes mid-window have no effect until the next window's first beat.
- Reset mid-window discards the partial window; no output is produced for it.

Optional Feature:
- Macro MAXPOOL_ARGMAX_EN.
- Defined:
  - The tree also returns the winning lane.
  - The accumulator stores idx = beat*LANES + lane.
  - The out_idx port exists.
  - Index follows the same tie rule (earliest wins).
- Undefined: out_idx port and index logic are removed; out_max behaviour is identical.

Decomposition:
- Package maxpool_pkg:
  - Index-width and count-width localparam functions (clog2-based).
  - FSM state enum {ACCUM, OUT}.
  - Compare function gt(a, b, signed_mode).
- Sub-module maxpool_tree:
  - Purely combinational, log2(LANES) levels of compare/mux.
  - Inputs LANES*W; outputs max and lane index.
  - Lower lane wins ties.
  - LANES=1 passes lane 0 through.

Test Plan:
- W=16, LANES=16, cfg_beats=1, lanes 0..15 = 3,9,...,9 (9 first at lane 1), out_ready=1 -> out_max=9, out_idx=1, out_valid one cycle after the handshake.
- cfg_beats=3, beat maxima 100, 250, 250 (the second 250 at lane 4 of beat 2) -> out_max=250, out_idx=beat1 lane, never 2*16+4.
- SIGNED=1, lanes containing 0xFFFF (-1) and 0x0002, rest 0x8000 -> out_max=0x0002. SIGNED=0 with the same data -> 0xFFFF.
- out_ready=0 for 5 cycles after a result, in_valid=1 -> in_ready=0, out_max stable. On out_ready=1, the next window's first beat is accepted in the same cycle.
- cfg_beats=0 -> treated as 1 window per beat. Back-to-back beats with out_ready=1 -> one result per cycle.
- Assert rst_n low after 2 of 4 beats -> out_valid=0, the next 4 beats produce a result from only those 4.
